lsu_mem_ctrl: RTL and testbench

- Load/store initiator between the datapath and the word-addressed data memory. It drives mem_address, write_data, MemRead and MemWrite, and samples read_data.
- Accepts one byte-addressed load or store at a time from the core and returns one response.
- Builds byte and halfword stores as a read-modify-write on the 32-bit memory word.
- Extracts and sign- or zero-extends sub-word loads, and flags misaligned or out-of-range accesses without touching memory.

---
 rtl/lsu_mem_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: byte-addressed load/store initiator for a word-addressed data memory.
// Optional build macro LSU_ERR_STICKY_EN adds err_sticky / err_addr error capture.
module lsu_mem_ctrl #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] write_data,
    output logic        MemRead,
    output logic        MemWrite,
`ifdef LSU_ERR_STICKY_EN
    output logic        err_sticky,
    output logic [31:0] err_addr,
`endif
    input  logic [31:0] read_data
);

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_R = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RMW_RD,
        S_WR,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic        accept;
    logic        req_err;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [15:0] wdata_q;
    logic        err_q;
    logic [31:0] maddr_q;
    logic [31:0] wr_data_q;
    logic [31:0] rdata_q;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] store_merge;

    assign accept = (state_q == S_IDLE) & req_valid;

    // Classify the incoming request as misaligned, reserved or out of range
    always_comb begin
        req_err = 1'b0;
        unique case (req_size)
            SZ_B: req_err = 1'b0;
            SZ_H: req_err = req_addr[0];
            SZ_W: req_err = (req_addr[1:0] != 2'b00);
            SZ_R: req_err = 1'b1;
            default: req_err = 1'b1;
        endcase
        if (|req_addr[31:ADDR_WIDTH+2]) begin
            req_err = 1'b1;
        end
    end

    // Select the addressed lane of the read word and extend it
    always_comb begin
        byte_sel = 8'(read_data >> {lane_q, 3'b000});
        half_sel = lane_q[1] ? read_data[31:16] : read_data[15:0];
        load_ext = read_data;
        unique case (size_q)
            SZ_B: load_ext = signed_q ? {{24{byte_sel[7]}}, byte_sel}
                                      : {24'h0, byte_sel};
            SZ_H: load_ext = signed_q ? {{16{half_sel[15]}}, half_sel}
                                      : {16'h0, half_sel};
            default: load_ext = read_data;
        endcase
    end

    // Merge the new byte/halfword into the old word for read-modify-write
    always_comb begin
        store_merge = read_data;
        unique case (size_q)
            SZ_B: store_merge[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
            SZ_H: store_merge[{lane_q[1], 4'b0000} +: 16] = wdata_q;
            default: store_merge = read_data;
        endcase
    end

    // State register; reset drops MemWrite at once since it decodes state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        state_d = S_RESP;
                    end else if (!req_we) begin
                        state_d = S_RD;
                    end else if (req_size == SZ_W) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_RD:     state_d = S_RESP;
            S_RMW_RD: state_d = S_WR;
            S_WR:     state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        req_ready  = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        resp_valid = 1'b0;
        unique case (state_q)
            S_IDLE:   req_ready  = 1'b1;
            S_RD:     MemRead    = 1'b1;
            S_RMW_RD: MemRead    = 1'b1;
            S_WR:     MemWrite   = 1'b1;
            S_RESP:   resp_valid = 1'b1;
            default:  req_ready  = 1'b0;
        endcase
        resp_err    = resp_valid & err_q;
        resp_rdata  = rdata_q;
        mem_address = maddr_q;
        write_data  = wr_data_q;
    end

    // Request capture, load result capture and store word build
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q    <= 2'b00;
            size_q    <= 2'b00;
            signed_q  <= 1'b0;
            wdata_q   <= 16'h0;
            err_q     <= 1'b0;
            maddr_q   <= 32'h0;
            wr_data_q <= 32'h0;
            rdata_q   <= 32'h0;
        end else begin
            if (accept) begin
                lane_q   <= req_addr[1:0];
                size_q   <= req_size;
                signed_q <= req_signed;
                wdata_q  <= req_wdata[15:0];
                err_q    <= req_err;
                maddr_q  <= {{(32-ADDR_WIDTH){1'b0}},
                             req_addr[ADDR_WIDTH+1:2]};
                rdata_q  <= 32'h0;
                if (req_we && (req_size == SZ_W) && !req_err) begin
                    wr_data_q <= req_wdata;
                end
            end
            if (state_q == S_RD) begin
                rdata_q <= load_ext;
            end
            if (state_q == S_RMW_RD) begin
                wr_data_q <= store_merge;
            end
        end
    end

`ifdef LSU_ERR_STICKY_EN
    logic        sticky_q;
    logic [31:0] err_addr_q;

    // Remember that an error happened and where the first one was
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_q   <= 1'b0;
            err_addr_q <= 32'h0;
        end else if (accept && req_err) begin
            sticky_q <= 1'b1;
            if (!sticky_q) begin
                err_addr_q <= req_addr;
            end
        end
    end

    assign err_sticky = sticky_q;
    assign err_addr   = err_addr_q;
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed vector table plus reset and backpressure
// sequences for lsu_mem_ctrl against a behavioural word memory.
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] write_data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] read_data;
`ifdef LSU_ERR_STICKY_EN
    logic        err_sticky;
    logic [31:0] err_addr;
`endif

    int n_pass  = 0;
    int n_total = 0;

    lsu_mem_ctrl #(.ADDR_WIDTH(8)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_size(req_size),
        .req_signed(req_signed),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .mem_address(mem_address),
        .write_data(write_data),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
`ifdef LSU_ERR_STICKY_EN
        .err_sticky(err_sticky),
        .err_addr(err_addr),
`endif
        .read_data(read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [256];

    assign read_data = mem[mem_address[7:0]];

    always @(posedge clk) begin
        if (MemWrite) begin
            mem[mem_address[7:0]] <= write_data;
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_maddr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic [1:0] size,
                                input logic sgn, input logic [31:0] addr,
                                input logic [31:0] wdata,
                                input logic [31:0] exp_rdata,
                                input logic exp_err, input int exp_lat,
                                input logic [31:0] exp_maddr,
                                input logic [31:0] exp_wdata);
        vec_t v;
        v.we = we;
        v.size = size;
        v.sgn = sgn;
        v.addr = addr;
        v.wdata = wdata;
        v.exp_rdata = exp_rdata;
        v.exp_err = exp_err;
        v.exp_lat = exp_lat;
        v.exp_maddr = exp_maddr;
        v.exp_wdata = exp_wdata;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          lat;
        int          nrd;
        int          nwr;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] wd_seen;
        logic [31:0] rd_got;
        logic [31:0] ma;
        logic        er;
        string       tag;
        tag = $sformatf("v%0d", idx);
        lat = 0;
        nrd = 0;
        nwr = 0;
        wd_seen = 32'h0;
        rd_got = 32'h0;
        ma = 32'h0;
        er = 1'b0;
        @(negedge clk);
        chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int n = 1; n <= 6 && lat == 0; n++) begin
            @(negedge clk);
            if (MemRead) nrd++;
            if (MemWrite) begin
                nwr++;
                wd_seen = write_data;
            end
            if (MemRead && MemWrite) begin
                chk({tag, "_excl"}, 32'd1, 32'd0);
            end
            if (resp_valid) begin
                lat = n;
                rd_got = resp_rdata;
                er = resp_err;
                ma = mem_address;
            end
        end
        if (lat == 0) begin
            n_total++;
            $display("FAIL %s_timeout: got no resp_valid required one", tag);
            return;
        end
        if (v.exp_err) begin
            exp_rd = 0;
            exp_wr = 0;
        end else if (!v.we) begin
            exp_rd = 1;
            exp_wr = 0;
        end else if (v.size == 2'b10) begin
            exp_rd = 0;
            exp_wr = 1;
        end else begin
            exp_rd = 1;
            exp_wr = 1;
        end
        chk({tag, "_lat"}, lat, v.exp_lat);
        chk({tag, "_err"}, {31'b0, er}, {31'b0, v.exp_err});
        chk({tag, "_rdata"}, rd_got, v.exp_rdata);
        chk({tag, "_maddr"}, ma, v.exp_maddr);
        chk({tag, "_nrd"}, nrd, exp_rd);
        chk({tag, "_nwr"}, nwr, exp_wr);
        if (exp_wr == 1) begin
            chk({tag, "_wdata"}, wd_seen, v.exp_wdata);
        end
    endtask

    int          acc_n;
    int          nresp;
    int          resp_n [2];
    logic [31:0] resp_d [2];
    logic [31:0] resp_a [2];
    logic        ready_n1;

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;

        // stimulus table: we size sgn addr wdata | rdata err lat maddr wdata
        vecs.push_back(mk(1, 2'b10, 0, 32'h10, 32'hDEADBEEF,
                          32'h0, 0, 2, 32'd4, 32'hDEADBEEF));
        vecs.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0,
                          32'hDEADBEEF, 0, 2, 32'd4, 32'h0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h10, 32'h11223344,
                          32'h0, 0, 2, 32'd4, 32'h11223344));
        vecs.push_back(mk(1, 2'b00, 0, 32'h12, 32'h000000AA,
                          32'h0, 0, 3, 32'd4, 32'h11AA3344));
        vecs.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0,
                          32'h11AA3344, 0, 2, 32'd4, 32'h0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h10, 32'h80FF7F01,
                          32'h0, 0, 2, 32'd4, 32'h80FF7F01));
        vecs.push_back(mk(0, 2'b00, 1, 32'h11, 32'h0,
                          32'h0000007F, 0, 2, 32'd4, 32'h0));
        vecs.push_back(mk(0, 2'b00, 1, 32'h12, 32'h0,
                          32'hFFFFFFFF, 0, 2, 32'd4, 32'h0));
        vecs.push_back(mk(0, 2'b01, 0, 32'h12, 32'h0,
                          32'h000080FF, 0, 2, 32'd4, 32'h0));
        vecs.push_back(mk(0, 2'b01, 1, 32'h12, 32'h0,
                          32'hFFFF80FF, 0, 2, 32'd4, 32'h0));
        vecs.push_back(mk(0, 2'b00, 0, 32'h13, 32'h0,
                          32'h00000080, 0, 2, 32'd4, 32'h0));
        vecs.push_back(mk(0, 2'b00, 1, 32'h13, 32'h0,
                          32'hFFFFFF80, 0, 2, 32'd4, 32'h0));
        vecs.push_back(mk(0, 2'b01, 1, 32'h10, 32'h0,
                          32'h00007F01, 0, 2, 32'd4, 32'h0));
        vecs.push_back(mk(1, 2'b01, 0, 32'h12, 32'h00001234,
                          32'h0, 0, 3, 32'd4, 32'h12347F01));
        vecs.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0,
                          32'h12347F01, 0, 2, 32'd4, 32'h0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h13, 32'h0,
                          32'h0, 1, 1, 32'd4, 32'h0));
        vecs.push_back(mk(1, 2'b01, 0, 32'h11, 32'h0000BEEF,
                          32'h0, 1, 1, 32'd4, 32'h0));
        vecs.push_back(mk(0, 2'b11, 0, 32'h10, 32'h0,
                          32'h0, 1, 1, 32'd4, 32'h0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h400, 32'h0,
                          32'h0, 1, 1, 32'd0, 32'h0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h14, 32'hCAFEF00D,
                          32'h0, 0, 2, 32'd5, 32'hCAFEF00D));

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_memread", {31'b0, MemRead}, 32'd0);
        chk("rst_memwrite", {31'b0, MemWrite}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_maddr", mem_address, 32'h0);
        chk("rst_wdata", write_data, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);

        foreach (vecs[i]) begin
            run_vec(i, vecs[i]);
        end

`ifdef LSU_ERR_STICKY_EN
        chk("sticky", {31'b0, err_sticky}, 32'd1);
        chk("sticky_addr", err_addr, 32'h13);
`endif

        // reset during the write phase of a byte store to 0x12
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h12;
        req_wdata  = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_wr_memwrite", {31'b0, MemWrite}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_async_drop", {31'b0, MemWrite}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("mid_mem4", mem[4], 32'h12347F01);
        chk("mid_memread", {31'b0, MemRead}, 32'd0);
        chk("mid_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("mid_maddr", mem_address, 32'h0);
        chk("mid_wdata", write_data, 32'h0);
        chk("mid_rdata", resp_rdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_ready", {31'b0, req_ready}, 32'd1);
        chk("mid_no_resp", {31'b0, resp_valid}, 32'd0);

        // request held during a busy load must wait for IDLE
        acc_n = 0;
        nresp = 0;
        ready_n1 = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = 32'h10;
        @(posedge clk);
        #1 req_addr = 32'h14;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            if (n == 1) ready_n1 = req_ready;
            if (resp_valid) begin
                if (nresp < 2) begin
                    resp_n[nresp] = n;
                    resp_d[nresp] = resp_rdata;
                    resp_a[nresp] = mem_address;
                end
                nresp++;
            end
            if (req_ready && req_valid) begin
                acc_n = n;
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
        end
        chk("bp_ready_busy", {31'b0, ready_n1}, 32'd0);
        chk("bp_accept_cycle", acc_n, 32'd3);
        chk("bp_nresp", nresp, 32'd2);
        if (nresp >= 2) begin
            chk("bp_r0_cycle", resp_n[0], 32'd2);
            chk("bp_r0_data", resp_d[0], 32'h12347F01);
            chk("bp_r0_maddr", resp_a[0], 32'd4);
            chk("bp_r1_cycle", resp_n[1], 32'd5);
            chk("bp_r1_data", resp_d[1], 32'hCAFEF00D);
            chk("bp_r1_maddr", resp_a[1], 32'd5);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
